// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter sequencing one source->destination byte move per grant
// over the shared bus, with registered selects, destination registers and done pulses.
module bus_transfer_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RR_INIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic             src_sel0,
  input  logic             dst_sel0,
  input  logic             src_sel1,
  input  logic             dst_sel1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             busy,
  output logic             bus_from,
  output logic             bus_to,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             out0_valid,
  output logic             out1_valid
);

  typedef enum logic [1:0] {IDLE, SELECT, XFER} state_t;

  localparam logic PTR_RESET = (RR_INIT != 0);

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             from_q, from_d;
  logic             to_q, to_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic             v0_q, v0_d;
  logic             v1_q, v1_d;
  logic             win;
  logic [WIDTH-1:0] bus_byte;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    from_d   = from_q;
    to_d     = to_q;
    ptr_d    = ptr_q;
    out0_d   = out0_q;
    out1_d   = out1_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    win      = ptr_q;
    bus_byte = from_q ? in0 : in1;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          // A lone requester wins outright; the pointer only breaks ties.
          win     = (req == 2'b11) ? ptr_q : req[1];
          grant_d = win ? 2'b10 : 2'b01;
          from_d  = win ? src_sel1 : src_sel0;
          to_d    = win ? dst_sel1 : dst_sel0;
          state_d = SELECT;
        end
      end
      SELECT: state_d = XFER;
      XFER: begin
        if (to_q) begin
          out0_d = bus_byte;
          v0_d   = 1'b1;
        end else begin
          out1_d = bus_byte;
          v1_d   = 1'b1;
        end
        done_d  = grant_q;
        ptr_d   = ~grant_q[1];
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      from_q  <= 1'b0;
      to_q    <= 1'b0;
      ptr_q   <= PTR_RESET;
      out0_q  <= '0;
      out1_q  <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      from_q  <= from_d;
      to_q    <= to_d;
      ptr_q   <= ptr_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign bus_from   = from_q;
  assign bus_to     = to_q;
  assign out0       = out0_q;
  assign out1       = out1_q;
  assign out0_valid = v0_q;
  assign out1_valid = v1_q;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Directed bench for bus_transfer_arbiter: inputs driven 1 time unit after
// each rising edge, outputs checked at that same point.
module tb_bus_transfer_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic       src_sel0, dst_sel0, src_sel1, dst_sel1;
  logic [7:0] in0, in1;
  logic [1:0] grant, done;
  logic       busy, bus_from, bus_to;
  logic [7:0] out0, out1;
  logic       out0_valid, out1_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_transfer_arbiter #(.WIDTH(8), .RR_INIT(0)) dut (
    .clk(clk), .reset(reset), .req(req),
    .src_sel0(src_sel0), .dst_sel0(dst_sel0),
    .src_sel1(src_sel1), .dst_sel1(dst_sel1),
    .in0(in0), .in1(in1),
    .grant(grant), .done(done), .busy(busy),
    .bus_from(bus_from), .bus_to(bus_to),
    .out0(out0), .out1(out1),
    .out0_valid(out0_valid), .out1_valid(out1_valid)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  logic       exp_ptr, w, ws, wd;
  logic [7:0] exp_o0, exp_o1, exp_byte;
  logic       exp_v0, exp_v1;

  initial begin
    reset = 1'b1; req = '0;
    src_sel0 = 1'b0; dst_sel0 = 1'b0; src_sel1 = 1'b0; dst_sel1 = 1'b0;
    in0 = '0; in1 = '0;
    cyc(2);
    reset = 1'b0;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", {bus_from, bus_to}, 0);
    check("rst_outs", {out0, out1}, 0);
    check("rst_valid", {out0_valid, out1_valid}, 0);

    // 1: single transfer in0 -> out1
    req = 2'b01; src_sel0 = 1'b1; dst_sel0 = 1'b0; in0 = 8'hA5; in1 = 8'h00;
    cyc(1);
    check("t1_grant", grant, 2'b01);
    check("t1_busy", busy, 1);
    check("t1_sel", {bus_from, bus_to}, 2'b10);
    check("t1_done_early", done, 0);
    cyc(1);
    check("t1_grant_xfer", grant, 2'b01);
    check("t1_done_early2", done, 0);
    cyc(1);
    check("t1_done", done, 2'b01);
    check("t1_out1", out1, 8'hA5);
    check("t1_v1", out1_valid, 1);
    check("t1_out0", out0, 0);
    check("t1_v0", out0_valid, 0);
    check("t1_grant_clr", grant, 0);
    req = 2'b00;
    cyc(1);
    check("t1_done_pulse", done, 0);
    check("t1_idle", busy, 0);

    // 2: both requesting after reset, pointer starts at 0
    pulse_reset();
    req = 2'b11; src_sel0 = 1'b0; dst_sel0 = 1'b1; src_sel1 = 1'b1; dst_sel1 = 1'b0;
    in0 = 8'h3C; in1 = 8'hC3;
    cyc(1);
    check("t2_grant0", grant, 2'b01);
    cyc(2);
    check("t2_done0", done, 2'b01);
    check("t2_out0", out0, 8'hC3);
    req = 2'b10;
    cyc(1);
    check("t2_grant1", grant, 2'b10);
    check("t2_sel1", {bus_from, bus_to}, 2'b10);
    cyc(2);
    check("t2_done1", done, 2'b10);
    check("t2_out1", out1, 8'h3C);
    check("t2_out0_hold", out0, 8'hC3);
    req = 2'b00;
    cyc(1);

    // 3: both target out0, serialised; second write wins
    req = 2'b11; src_sel0 = 1'b1; dst_sel0 = 1'b1; src_sel1 = 1'b0; dst_sel1 = 1'b1;
    in0 = 8'h11; in1 = 8'h22;
    cyc(3);
    check("t3_done0", done, 2'b01);
    check("t3_out0_first", out0, 8'h11);
    req = 2'b10;
    cyc(3);
    check("t3_done1", done, 2'b10);
    check("t3_out0_second", out0, 8'h22);
    check("t3_out1_hold", out1, 8'h3C);
    req = 2'b00;
    cyc(1);

    // 4: request and source changed while in SELECT
    req = 2'b01; src_sel0 = 1'b1; dst_sel0 = 1'b0; in0 = 8'h5A; in1 = 8'hA5;
    cyc(1);
    check("t4_grant", grant, 2'b01);
    req = 2'b00; src_sel0 = 1'b0;
    cyc(1);
    check("t4_sel_latched", bus_from, 1);
    cyc(1);
    check("t4_done", done, 2'b01);
    check("t4_out1", out1, 8'h5A);
    cyc(1);
    check("t4_no_restart", busy, 0);

    // 5: reset during XFER
    req = 2'b01; src_sel0 = 1'b0; dst_sel0 = 1'b1; in1 = 8'h77;
    cyc(2);
    check("t5_busy_xfer", busy, 1);
    reset = 1'b1; req = 2'b00;
    #1;
    check("t5_async_outs", {out0, out1}, 0);
    check("t5_async_valid", {out0_valid, out1_valid}, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_grant", grant, 0);
    cyc(1);
    check("t5_no_done", done, 0);
    check("t5_out0_unwritten", out0, 0);
    reset = 1'b0;
    req = 2'b11; src_sel0 = 1'b1; dst_sel0 = 1'b1; src_sel1 = 1'b0; dst_sel1 = 1'b0;
    in0 = 8'h99;
    cyc(1);
    check("t5_ptr_init", grant, 2'b01);
    req = 2'b00;
    cyc(2);
    check("t5_done", done, 2'b01);
    check("t5_out0", out0, 8'h99);
    cyc(1);

    // 6: held 11-request stress with random data and selects
    exp_ptr = 1'b1; exp_o0 = 8'h99; exp_o1 = 8'h00; exp_v0 = 1'b1; exp_v1 = 1'b0;
    src_sel0 = 1'($urandom_range(0, 1)); dst_sel0 = 1'($urandom_range(0, 1));
    src_sel1 = 1'($urandom_range(0, 1)); dst_sel1 = 1'($urandom_range(0, 1));
    req = 2'b11;
    for (int k = 0; k < 10; k++) begin
      w  = exp_ptr;
      ws = w ? src_sel1 : src_sel0;
      wd = w ? dst_sel1 : dst_sel0;
      cyc(1);
      check("t6_grant", grant, w ? 2'b10 : 2'b01);
      check("t6_from", bus_from, ws);
      check("t6_to", bus_to, wd);
      in0 = 8'($urandom); in1 = 8'($urandom);
      src_sel0 = ~src_sel0; src_sel1 = ~src_sel1;
      exp_byte = ws ? in0 : in1;
      cyc(1);
      check("t6_grant_hold", grant, w ? 2'b10 : 2'b01);
      check("t6_no_early_done", done, 0);
      if (wd) begin exp_o0 = exp_byte; exp_v0 = 1'b1; end
      else    begin exp_o1 = exp_byte; exp_v1 = 1'b1; end
      cyc(1);
      check("t6_done", done, w ? 2'b10 : 2'b01);
      check("t6_grant_clr", grant, 0);
      check("t6_out0", out0, exp_o0);
      check("t6_out1", out1, exp_o1);
      check("t6_valid", {out0_valid, out1_valid}, {exp_v0, exp_v1});
      exp_ptr = ~exp_ptr;
      src_sel0 = 1'($urandom_range(0, 1)); dst_sel0 = 1'($urandom_range(0, 1));
      src_sel1 = 1'($urandom_range(0, 1)); dst_sel1 = 1'($urandom_range(0, 1));
    end
    req = 2'b00;
    cyc(4);
    check("t6_idle", busy, 0);
    check("t6_done_idle", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
